// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state type and default width for the bit-serial adder.
// The optional subtract mode (SERIAL_ADDER_SUB_EN) needs nothing from this package.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/full_adder_bit.sv
// full_adder_bit: combinational 1-bit full-adder cell, time-shared by serial_adder_ctrl.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder_bit

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands one bit per clock, LSB first, through a single
// full_adder_bit cell. Defining SERIAL_ADDER_SUB_EN adds a sub port selecting a-b.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               fa_b, fa_s, fa_c;

`ifdef SERIAL_ADDER_SUB_EN
    logic               sub_q, sub_d;

    // Subtraction is a + ~b + 1: invert the B bit and seed the carry with 1.
    assign fa_b = b_sh_q[0] ^ sub_q;
`else
    assign fa_b = b_sh_q[0];
`endif

    full_adder_bit u_fa (
        .a    (a_sh_q[0]),
        .b    (fa_b),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d   = sub;
                    carry_d = sub;
`else
                    carry_d = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                carry_d = fa_c;
                if (cnt_q == LAST) begin
                    sum_d   = acc_d;
                    cout_d  = fa_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder_ctrl
